divide_by_n: RTL and testbench

//  Iterative restoring divider: unsigned NUM_W-bit numerator / runtime DEN_W-bit divisor.

---
 rtl/divide_by_n_pkg.sv | 20 ++
 rtl/divide_by_n_if.sv | 28 ++
 rtl/divide_by_n_step.sv | 20 ++
 rtl/divide_by_n.sv | 105 ++++++++++
 tb/tb_divide_by_n.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/divide_by_n_pkg.sv
// Shared types for the iterative restoring divider: FSM encoding and a
// constant-evaluable ceiling log2 used to size the step counter.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/divide_by_n_if.sv
// Request/response bundle for the divider: a valid/ready request carrying the
// operands and a valid/ready response carrying quotient, remainder and the zero flag.
interface divide_by_n_if #(
    parameter int NUM_W = 6,
    parameter int DEN_W = 4
);

    logic             in_valid;
    logic             in_ready;
    logic [NUM_W-1:0] numerator;
    logic [DEN_W-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [NUM_W-1:0] quotient;
    logic [DEN_W-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, numerator, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, numerator, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/divide_by_n_step.sv
// One combinational restoring-division step: shift the next numerator bit into the
// partial remainder and subtract the divisor when it fits.
module divide_step #(
    parameter int DEN_W = 4
) (
    input  logic [DEN_W-1:0] rem,
    input  logic             next_bit,
    input  logic [DEN_W-1:0] den,
    output logic [DEN_W-1:0] rem_next,
    output logic             qbit
);

    logic [DEN_W:0] t;

    // rem < den always holds, so t < 2*den and t - den fits back into DEN_W bits.
    assign t        = {rem, next_bit};
    assign qbit     = (t >= {1'b0, den});
    assign rem_next = qbit ? DEN_W'(t - {1'b0, den}) : t[DEN_W-1:0];

endmodule

// File: rtl/divide_by_n.sv
// Iterative unsigned divider resolving one quotient bit per clock behind
// valid/ready handshakes; a zero divisor completes immediately with a flagged result.
module divide_by_n
    import divider_pkg::*;
#(
    parameter int NUM_W = 6,
    parameter int DEN_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    divide_by_n_if.slave  bus
);

    localparam int CNT_W = clog2(NUM_W + 1);

    state_t           state;
    state_t           state_next;
    logic [NUM_W-1:0] num_sh;
    logic [DEN_W-1:0] den;
    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] rem_next;
    logic [CNT_W-1:0] count;
    logic             dbz;
    logic             qbit;
    logic             accept;
    logic             last_step;

    assign accept    = bus.in_valid && bus.in_ready;
    assign last_step = (count == CNT_W'(NUM_W - 1));

    // Results are gated by out_valid so nothing partial leaks out during BUSY or reset.
    assign bus.in_ready    = rst_n && (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quotient    = bus.out_valid ? num_sh : '0;
    assign bus.remainder   = bus.out_valid ? rem : '0;
    assign bus.div_by_zero = bus.out_valid && dbz;

    divide_step #(
        .DEN_W (DEN_W)
    ) u_step (
        .rem      (rem),
        .next_bit (num_sh[NUM_W-1]),
        .den      (den),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (bus.divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The quotient shifts in from the bottom as the numerator shifts out of the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_sh <= '0;
            den    <= '0;
            rem    <= '0;
            count  <= '0;
            dbz    <= 1'b0;
        end else if (accept) begin
            count <= '0;
            den   <= bus.divisor;
            if (bus.divisor == '0) begin
                num_sh <= '1;
                rem    <= bus.numerator[DEN_W-1:0];
                dbz    <= 1'b1;
            end else begin
                num_sh <= bus.numerator;
                rem    <= '0;
                dbz    <= 1'b0;
            end
        end else if (state == BUSY) begin
            num_sh <= {num_sh[NUM_W-2:0], qbit};
            rem    <= rem_next;
            count  <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_divide_by_n.sv
// Directed self-checking bench for divide_by_n (NUM_W=6, DEN_W=4), including an
// exhaustive operand sweep against the language's / and % operators.
module tb_divide_by_n;

    localparam int NUM_W    = 6;
    localparam int DEN_W    = 4;
    localparam int MAX_WAIT = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    divide_by_n_if #(.NUM_W(NUM_W), .DEN_W(DEN_W)) bus ();

    divide_by_n #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic send(input int num, input int den);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.numerator = NUM_W'(num);
        bus.divisor   = DEN_W'(den);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid; -1 means it never came.
    task automatic wait_done(output int cycles);
        int i = 0;
        while (!bus.out_valid && i < MAX_WAIT) begin
            @(posedge clk);
            #1;
            i++;
        end
        cycles = bus.out_valid ? i : -1;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.quotient !== 6'd0) begin failures++; $display("[TB] FAIL reset_quotient: got %0d expected 0", bus.quotient); end
        checks++; if (bus.remainder !== 4'd0) begin failures++; $display("[TB] FAIL reset_remainder: got %0d expected 0", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int c;
        send(45, 12);
        wait_done(c);
        checks++; if (c != 6) begin failures++; $display("[TB] FAIL basic_latency: got %0d expected 6", c); end
        checks++; if (bus.quotient !== 6'd3) begin failures++; $display("[TB] FAIL basic_quotient: got %0d expected 3", bus.quotient); end
        checks++; if (bus.remainder !== 4'd9) begin failures++; $display("[TB] FAIL basic_remainder: got %0d expected 9", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin failures++; $display("[TB] FAIL basic_dbz: got %b expected 0", bus.div_by_zero); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL basic_in_ready_done: got %b expected 0", bus.in_ready); end
        consume();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL basic_return_idle: got out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_div_zero();
        int c;
        send(37, 0);
        wait_done(c);
        checks++; if (c != 0) begin failures++; $display("[TB] FAIL dbz_latency: got %0d expected 0", c); end
        checks++; if (bus.quotient !== 6'd63) begin failures++; $display("[TB] FAIL dbz_quotient: got %0d expected 63", bus.quotient); end
        checks++; if (bus.remainder !== 4'd5) begin failures++; $display("[TB] FAIL dbz_remainder: got %0d expected 5", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b1) begin failures++; $display("[TB] FAIL dbz_flag: got %b expected 1", bus.div_by_zero); end
        consume();
    endtask

    task automatic test_values();
        int vec_num [3] = '{63, 5, 12};
        int vec_den [3] = '{1, 12, 12};
        int vec_q   [3] = '{63, 0, 1};
        int vec_r   [3] = '{0, 5, 0};
        int c;
        for (int k = 0; k < 3; k++) begin
            send(vec_num[k], vec_den[k]);
            wait_done(c);
            checks++;
            if (c != 6 || bus.quotient !== 6'(vec_q[k]) || bus.remainder !== 4'(vec_r[k]) || bus.div_by_zero !== 1'b0) begin
                failures++;
                $display("[TB] FAIL value_%0d_by_%0d: got lat=%0d q=%0d r=%0d dbz=%b expected lat=6 q=%0d r=%0d dbz=0",
                         vec_num[k], vec_den[k], c, bus.quotient, bus.remainder, bus.div_by_zero, vec_q[k], vec_r[k]);
            end
            consume();
        end
    endtask

    task automatic test_hold();
        int c;
        send(45, 12);
        wait_done(c);
        bus.in_valid  = 1'b1;
        bus.numerator = 6'd50;
        bus.divisor   = 4'd7;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 6'd3 || bus.remainder !== 4'd9 || bus.div_by_zero !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_cycle_%0d: got ov=%b ir=%b q=%0d r=%0d dbz=%b expected 1/0/3/9/0",
                         k, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero);
            end
        end
        consume();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_after_handshake: got ir=%b ov=%b expected 1/0", bus.in_ready, bus.out_valid); end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_done(c);
        checks++;
        if (c != 6 || bus.quotient !== 6'd7 || bus.remainder !== 4'd1) begin
            failures++;
            $display("[TB] FAIL hold_second_request: got lat=%0d q=%0d r=%0d expected lat=6 q=7 r=1", c, bus.quotient, bus.remainder);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int c;
        send(45, 12);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_in_ready: got %b expected 0", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.quotient !== 6'd0 || bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_outputs: got ov=%b q=%0d r=%0d dbz=%b expected all 0", bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_release: got ir=%b ov=%b expected 1/0", bus.in_ready, bus.out_valid); end
        send(20, 7);
        wait_done(c);
        checks++;
        if (c != 6 || bus.quotient !== 6'd2 || bus.remainder !== 4'd6) begin
            failures++;
            $display("[TB] FAIL after_reset_divide: got lat=%0d q=%0d r=%0d expected lat=6 q=2 r=6", c, bus.quotient, bus.remainder);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int accepts[$];
        int results = 0;
        int drain   = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.numerator = 6'd45;
        bus.divisor   = 4'd12;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 42; cyc++) begin
            if (bus.in_ready && bus.in_valid) accepts.push_back(cyc);
            if (bus.out_valid) begin
                results++;
                checks++;
                if (bus.quotient !== 6'd3 || bus.remainder !== 4'd9) begin
                    failures++;
                    $display("[TB] FAIL b2b_result_cycle_%0d: got q=%0d r=%0d expected q=3 r=9", cyc, bus.quotient, bus.remainder);
                end
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        while (!bus.in_ready && drain < MAX_WAIT) begin
            @(negedge clk);
            drain++;
        end
        bus.out_ready = 1'b0;
        checks++; if (accepts.size() != 6) begin failures++; $display("[TB] FAIL b2b_accept_count: got %0d expected 6", accepts.size()); end
        checks++; if (results != 5) begin failures++; $display("[TB] FAIL b2b_result_count: got %0d expected 5", results); end
        for (int k = 1; k < accepts.size(); k++) begin
            checks++;
            if (accepts[k] - accepts[k-1] != NUM_W + 2) begin
                failures++;
                $display("[TB] FAIL b2b_spacing_%0d: got %0d expected %0d", k, accepts[k] - accepts[k-1], NUM_W + 2);
            end
        end
    endtask

    task automatic test_sweep();
        int c;
        int exp_lat;
        logic [NUM_W-1:0] exp_q;
        logic [DEN_W-1:0] exp_r;
        logic             exp_z;
        for (int n = 0; n < 64; n++) begin
            for (int d = 0; d < 16; d++) begin
                send(n, d);
                wait_done(c);
                if (d == 0) begin
                    exp_q = '1; exp_r = DEN_W'(n % 16); exp_z = 1'b1; exp_lat = 0;
                end else begin
                    exp_q = NUM_W'(n / d); exp_r = DEN_W'(n % d); exp_z = 1'b0; exp_lat = NUM_W;
                end
                checks++;
                if (c != exp_lat || bus.quotient !== exp_q || bus.remainder !== exp_r || bus.div_by_zero !== exp_z) begin
                    failures++;
                    $display("[TB] FAIL sweep_%0d_by_%0d: got lat=%0d q=%0d r=%0d dbz=%b expected lat=%0d q=%0d r=%0d dbz=%b",
                             n, d, c, bus.quotient, bus.remainder, bus.div_by_zero, exp_lat, exp_q, exp_r, exp_z);
                end
                consume();
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.numerator = '0;
        bus.divisor   = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_values();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
